// File: rtl/regread_pipe_if.sv
// Bundle of issue, register-file, CSR, bypass and execute signals for regread_pipe.
// The slave modport is the register-read stage; the master modport is its environment.
interface regread_pipe_if #(
  parameter int N_LANES = 4,
  parameter int N_BYP   = 4,
  parameter int DATA_W  = 64,
  parameter int TAG_W   = 7,
  parameter int PAY_W   = 128,
  parameter int CSR_AW  = 12
);
  logic                        recover_i;
  logic [N_LANES-1:0]          in_valid_i;
  logic [N_LANES*TAG_W-1:0]    in_src1_i;
  logic [N_LANES*TAG_W-1:0]    in_src2_i;
  logic [N_LANES-1:0]          in_is_csr_i;
  logic [CSR_AW-1:0]           in_csr_addr_i;
  logic [N_LANES*PAY_W-1:0]    in_payload_i;
  logic [N_LANES*TAG_W-1:0]    rf_raddr1_o;
  logic [N_LANES*TAG_W-1:0]    rf_raddr2_o;
  logic [N_LANES*DATA_W-1:0]   rf_rdata1_i;
  logic [N_LANES*DATA_W-1:0]   rf_rdata2_i;
  logic                        csr_rd_en_o;
  logic [CSR_AW-1:0]           csr_rd_addr_o;
  logic [DATA_W-1:0]           csr_rdata_i;
  logic [N_BYP-1:0]            byp_valid_i;
  logic [N_BYP*TAG_W-1:0]      byp_tag_i;
  logic [N_BYP*DATA_W-1:0]     byp_data_i;
  logic [N_LANES-1:0]          exe_valid_o;
  logic [N_LANES*DATA_W-1:0]   exe_src1_o;
  logic [N_LANES*DATA_W-1:0]   exe_src2_o;
  logic [N_LANES*PAY_W-1:0]    exe_payload_o;

  modport master (
    output recover_i, in_valid_i, in_src1_i, in_src2_i, in_is_csr_i, in_csr_addr_i,
           in_payload_i, rf_rdata1_i, rf_rdata2_i, csr_rdata_i, byp_valid_i, byp_tag_i,
           byp_data_i,
    input  rf_raddr1_o, rf_raddr2_o, csr_rd_en_o, csr_rd_addr_o, exe_valid_o, exe_src1_o,
           exe_src2_o, exe_payload_o
  );

  modport slave (
    input  recover_i, in_valid_i, in_src1_i, in_src2_i, in_is_csr_i, in_csr_addr_i,
           in_payload_i, rf_rdata1_i, rf_rdata2_i, csr_rdata_i, byp_valid_i, byp_tag_i,
           byp_data_i,
    output rf_raddr1_o, rf_raddr2_o, csr_rd_en_o, csr_rd_addr_o, exe_valid_o, exe_src1_o,
           exe_src2_o, exe_payload_o
  );
endinterface

// File: rtl/regread_pipe.sv
// Multi-lane register-read stage: pipelines issued packets DEPTH cycles, merging RF,
// CSR (lane 0) and snooped bypass data into resolved operands; recovery kills in-flight work.
module regread_pipe #(
  parameter int N_LANES = 4,
  parameter int N_BYP   = 4,
  parameter int DEPTH   = 2,
  parameter int RF_LAT  = 1,
  parameter int DATA_W  = 64,
  parameter int TAG_W   = 7,
  parameter int PAY_W   = 128,
  parameter int CSR_AW  = 12
) (
  input  logic          clk,
  input  logic          reset,
  regread_pipe_if.slave bus
);

  // Position p of each array is where a packet sits in cycle t+p (p=0 is the input side).
  logic [N_LANES-1:0][DEPTH-1:0]             w_vld,  r_vld;
  logic [N_LANES-1:0][DEPTH-1:0]             w_csr,  r_csr;
  logic [N_LANES-1:0][DEPTH-1:0]             w_hit1, r_hit1;
  logic [N_LANES-1:0][DEPTH-1:0]             w_hit2, r_hit2;
  logic [N_LANES-1:0][DEPTH-1:0][TAG_W-1:0]  w_tag1, r_tag1;
  logic [N_LANES-1:0][DEPTH-1:0][TAG_W-1:0]  w_tag2, r_tag2;
  logic [N_LANES-1:0][DEPTH-1:0][DATA_W-1:0] w_d1,   r_d1;
  logic [N_LANES-1:0][DEPTH-1:0][DATA_W-1:0] w_d2,   r_d2;
  logic [N_LANES-1:0][DEPTH-1:0][PAY_W-1:0]  w_pay,  r_pay;
  logic                                      w_unused_csr;

  function automatic logic [DATA_W:0] f_byp_lookup(
    input logic [TAG_W-1:0]        tag,
    input logic [N_BYP-1:0]        vld,
    input logic [N_BYP*TAG_W-1:0]  tags,
    input logic [N_BYP*DATA_W-1:0] data
  );
    logic [DATA_W:0] res;
    res = '0;
    // Scanning downward lets the lowest-numbered matching source win.
    for (int b = N_BYP - 1; b >= 0; b--) begin
      if (vld[b] && (tags[b*TAG_W +: TAG_W] == tag)) begin
        res = {1'b1, data[b*DATA_W +: DATA_W]};
      end
    end
    return res;
  endfunction

  assign bus.rf_raddr1_o   = bus.in_src1_i;
  assign bus.rf_raddr2_o   = bus.in_src2_i;
  assign bus.csr_rd_en_o   = bus.in_valid_i[0] & bus.in_is_csr_i[0];
  assign bus.csr_rd_addr_o = bus.in_csr_addr_i;
  assign w_unused_csr      = ^bus.in_is_csr_i;

  // Next state of every position: shift in, then apply bypass / RF / CSR capture.
  always_comb begin
    logic              s_hit1;
    logic              s_hit2;
    logic [DATA_W-1:0] s_d1;
    logic [DATA_W-1:0] s_d2;
    logic [DATA_W:0]   s_lk1;
    logic [DATA_W:0]   s_lk2;
    int                q;
    w_vld  = '0;
    w_csr  = '0;
    w_hit1 = '0;
    w_hit2 = '0;
    w_tag1 = '0;
    w_tag2 = '0;
    w_d1   = '0;
    w_d2   = '0;
    w_pay  = '0;
    s_hit1 = 1'b0;
    s_hit2 = 1'b0;
    s_d1   = '0;
    s_d2   = '0;
    s_lk1  = '0;
    s_lk2  = '0;
    q      = 0;
    for (int l = 0; l < N_LANES; l++) begin
      for (int p = 0; p < DEPTH; p++) begin
        q = (p > 0) ? (p - 1) : 0;
        if (p == 0) begin
          w_vld[l][p]  = bus.in_valid_i[l];
          w_csr[l][p]  = (l == 0) ? bus.in_is_csr_i[0] : 1'b0;
          w_tag1[l][p] = bus.in_src1_i[l*TAG_W +: TAG_W];
          w_tag2[l][p] = bus.in_src2_i[l*TAG_W +: TAG_W];
          w_pay[l][p]  = bus.in_payload_i[l*PAY_W +: PAY_W];
          s_hit1       = 1'b0;
          s_hit2       = 1'b0;
          s_d1         = '0;
          s_d2         = '0;
        end else begin
          w_vld[l][p]  = r_vld[l][q];
          w_csr[l][p]  = r_csr[l][q];
          w_tag1[l][p] = r_tag1[l][q];
          w_tag2[l][p] = r_tag2[l][q];
          w_pay[l][p]  = r_pay[l][q];
          s_hit1       = r_hit1[l][q];
          s_hit2       = r_hit2[l][q];
          s_d1         = r_d1[l][q];
          s_d2         = r_d2[l][q];
        end
        s_lk1 = f_byp_lookup(w_tag1[l][p], bus.byp_valid_i, bus.byp_tag_i, bus.byp_data_i);
        s_lk2 = f_byp_lookup(w_tag2[l][p], bus.byp_valid_i, bus.byp_tag_i, bus.byp_data_i);
        if (s_lk1[DATA_W]) begin
          w_hit1[l][p] = 1'b1;
          w_d1[l][p]   = s_lk1[DATA_W-1:0];
        end else if ((p == RF_LAT) && !s_hit1) begin
          w_hit1[l][p] = s_hit1;
          w_d1[l][p]   = bus.rf_rdata1_i[l*DATA_W +: DATA_W];
        end else begin
          w_hit1[l][p] = s_hit1;
          w_d1[l][p]   = s_d1;
        end
        // A CSR read owns operand 2 outright; the bypass network is not consulted.
        if (w_csr[l][p]) begin
          w_hit2[l][p] = s_hit2;
          w_d2[l][p]   = (p == RF_LAT) ? bus.csr_rdata_i : s_d2;
        end else if (s_lk2[DATA_W]) begin
          w_hit2[l][p] = 1'b1;
          w_d2[l][p]   = s_lk2[DATA_W-1:0];
        end else if ((p == RF_LAT) && !s_hit2) begin
          w_hit2[l][p] = s_hit2;
          w_d2[l][p]   = bus.rf_rdata2_i[l*DATA_W +: DATA_W];
        end else begin
          w_hit2[l][p] = s_hit2;
          w_d2[l][p]   = s_d2;
        end
      end
    end
  end

  // Stage registers; recovery drops valids and hit flags but leaves data untouched.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_vld  <= '0;
      r_csr  <= '0;
      r_hit1 <= '0;
      r_hit2 <= '0;
      r_tag1 <= '0;
      r_tag2 <= '0;
      r_d1   <= '0;
      r_d2   <= '0;
      r_pay  <= '0;
    end else begin
      if (bus.recover_i) begin
        r_vld  <= '0;
        r_hit1 <= '0;
        r_hit2 <= '0;
      end else begin
        r_vld  <= w_vld;
        r_hit1 <= w_hit1;
        r_hit2 <= w_hit2;
      end
      r_csr  <= w_csr;
      r_tag1 <= w_tag1;
      r_tag2 <= w_tag2;
      r_d1   <= w_d1;
      r_d2   <= w_d2;
      r_pay  <= w_pay;
    end
  end

  // Execute packet comes straight from the last stage register.
  always_comb begin
    bus.exe_valid_o   = '0;
    bus.exe_src1_o    = '0;
    bus.exe_src2_o    = '0;
    bus.exe_payload_o = '0;
    for (int l = 0; l < N_LANES; l++) begin
      bus.exe_valid_o[l]                   = r_vld[l][DEPTH-1];
      bus.exe_src1_o[l*DATA_W +: DATA_W]   = r_d1[l][DEPTH-1];
      bus.exe_src2_o[l*DATA_W +: DATA_W]   = r_d2[l][DEPTH-1];
      bus.exe_payload_o[l*PAY_W +: PAY_W]  = r_pay[l][DEPTH-1];
    end
  end

endmodule

// File: tb/tb_regread_pipe.sv
// Scoreboard bench for regread_pipe: three instances (DEPTH/RF_LAT = 2/1, 3/0, 4/1)
// share one stimulus set; only the selected instance receives valid packets.
module tb_regread_pipe;
  localparam int NL = 4;
  localparam int NB = 4;
  localparam int DW = 64;
  localparam int TW = 7;
  localparam int PW = 128;
  localparam int CA = 12;

  typedef struct {
    int           dut;
    int           lane;
    int           cyc;
    logic [DW-1:0] s1;
    logic [DW-1:0] s2;
    logic [PW-1:0] pay;
  } exp_t;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              recover = 1'b0;
  int                sel = 0;
  int                cyc = 0;
  int                n_tests = 0;
  int                n_fail = 0;
  logic [NL-1:0]     in_valid = '0;
  logic [NL-1:0]     in_is_csr = '0;
  logic [NL*TW-1:0]  in_src1 = '0;
  logic [NL*TW-1:0]  in_src2 = '0;
  logic [CA-1:0]     in_csr_addr = '0;
  logic [NL*PW-1:0]  in_payload = '0;
  logic [NL*DW-1:0]  rf1 = '0;
  logic [NL*DW-1:0]  rf2 = '0;
  logic [DW-1:0]     csr_rdata = '0;
  logic [NB-1:0]     byp_valid = '0;
  logic [NB*TW-1:0]  byp_tag = '0;
  logic [NB*DW-1:0]  byp_data = '0;

  logic [NL-1:0]     ev [3];
  logic [NL*DW-1:0]  es1 [3];
  logic [NL*DW-1:0]  es2 [3];
  logic [NL*PW-1:0]  epay [3];
  logic [NL*TW-1:0]  raddr1 [3];
  logic [NL*TW-1:0]  raddr2 [3];
  logic              csr_en [3];
  logic [CA-1:0]     csr_addr [3];

  exp_t sbq[$];
  exp_t e;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar k = 0; k < 3; k++) begin : g_dut
    regread_pipe_if #(.N_LANES(NL), .N_BYP(NB), .DATA_W(DW), .TAG_W(TW), .PAY_W(PW),
                      .CSR_AW(CA)) bif ();
    assign bif.recover_i     = recover;
    assign bif.in_valid_i    = (sel == k) ? in_valid : '0;
    assign bif.in_src1_i     = in_src1;
    assign bif.in_src2_i     = in_src2;
    assign bif.in_is_csr_i   = in_is_csr;
    assign bif.in_csr_addr_i = in_csr_addr;
    assign bif.in_payload_i  = in_payload;
    assign bif.rf_rdata1_i   = rf1;
    assign bif.rf_rdata2_i   = rf2;
    assign bif.csr_rdata_i   = csr_rdata;
    assign bif.byp_valid_i   = byp_valid;
    assign bif.byp_tag_i     = byp_tag;
    assign bif.byp_data_i    = byp_data;
    assign ev[k]       = bif.exe_valid_o;
    assign es1[k]      = bif.exe_src1_o;
    assign es2[k]      = bif.exe_src2_o;
    assign epay[k]     = bif.exe_payload_o;
    assign raddr1[k]   = bif.rf_raddr1_o;
    assign raddr2[k]   = bif.rf_raddr2_o;
    assign csr_en[k]   = bif.csr_rd_en_o;
    assign csr_addr[k] = bif.csr_rd_addr_o;
    regread_pipe #(.N_LANES(NL), .N_BYP(NB), .DEPTH(k + 2), .RF_LAT((k == 1) ? 0 : 1),
                   .DATA_W(DW), .TAG_W(TW), .PAY_W(PW), .CSR_AW(CA)) u_dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bif)
    );
  end

  // Scoreboard: every valid output must match the oldest expectation exactly.
  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      for (int l = 0; l < NL; l++) begin
        if (ev[d][l] !== 1'b0) begin
          n_tests++;
          if (sbq.size() == 0) begin
            n_fail++;
            $display("FAIL sb_unexpected: dut%0d lane%0d valid=%b at cyc %0d, required no output",
                     d, l, ev[d][l], cyc);
          end else begin
            e = sbq.pop_front();
            if (e.dut != d || e.lane != l || e.cyc != cyc ||
                es1[d][l*DW +: DW] !== e.s1 || es2[d][l*DW +: DW] !== e.s2 ||
                epay[d][l*PW +: PW] !== e.pay) begin
              n_fail++;
              $display("FAIL sb_packet: got dut%0d lane%0d cyc%0d s1=%h s2=%h pay=%h, required dut%0d lane%0d cyc%0d s1=%h s2=%h pay=%h",
                       d, l, cyc, es1[d][l*DW +: DW], es2[d][l*DW +: DW], epay[d][l*PW +: PW],
                       e.dut, e.lane, e.cyc, e.s1, e.s2, e.pay);
            end
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid  = '0;
    in_is_csr = '0;
    byp_valid = '0;
    recover   = 1'b0;
  endtask

  function automatic void push(input int d, input int l, input int c, input logic [DW-1:0] s1,
                               input logic [DW-1:0] s2, input logic [PW-1:0] pay);
    exp_t x;
    x.dut = d; x.lane = l; x.cyc = c; x.s1 = s1; x.s2 = s2; x.pay = pay;
    sbq.push_back(x);
  endfunction

  task automatic test_reset();
    repeat (3) tick();
    for (int k = 0; k < 3; k++) begin
      n_tests++;
      if (ev[k] !== 4'b0) begin
        n_fail++; $display("FAIL reset_valid dut%0d: got %b, required 0000", k, ev[k]);
      end
    end
    n_tests++;
    if (es1[0] !== '0 || es2[0] !== '0 || epay[0] !== '0) begin
      n_fail++; $display("FAIL reset_data: got src1=%h src2=%h, required 0", es1[0], es2[0]);
    end
    n_tests++;
    if (csr_en[0] !== 1'b0) begin
      n_fail++; $display("FAIL reset_csr_en: got %b, required 0", csr_en[0]);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_rf_only();
    sel = 0; idle();
    in_valid = 4'b0001; in_src1[6:0] = 7'd5; in_src2[6:0] = 7'd6;
    in_payload[127:0] = 128'hA1;
    push(0, 0, cyc + 2, 64'hAA, 64'hBB, 128'hA1);
    #1;
    n_tests++;
    if (raddr1[0][6:0] !== 7'd5 || raddr2[0][6:0] !== 7'd6) begin
      n_fail++; $display("FAIL raddr: got %0d/%0d, required 5/6", raddr1[0][6:0], raddr2[0][6:0]);
    end
    tick(); in_valid = '0; rf1[63:0] = 64'hAA; rf2[63:0] = 64'hBB;
    // Bypass arriving at t+DEPTH is outside the snoop window and must be ignored.
    tick(); rf1[63:0] = 64'hFFFF; rf2[63:0] = 64'hFFFF;
    byp_valid = 4'b0001; byp_tag[6:0] = 7'd5; byp_data[63:0] = 64'h99;
    tick(); idle();
    repeat (2) tick();
  endtask

  task automatic test_bypass();
    sel = 0; idle();
    in_valid = 4'b0011;
    in_src1[6:0] = 7'd5; in_src2[6:0] = 7'd6; in_src1[13:7] = 7'd9; in_src2[13:7] = 7'd10;
    in_payload[127:0] = 128'hB0; in_payload[255:128] = 128'hB1;
    push(0, 0, cyc + 2, 64'h11, 64'hBB, 128'hB0);
    push(0, 1, cyc + 2, 64'h77, 64'h88, 128'hB1);
    tick(); in_valid = '0;
    rf1[63:0] = 64'hAA; rf1[127:64] = 64'h77; rf2[63:0] = 64'hBB; rf2[127:64] = 64'h88;
    byp_valid = 4'b0100; byp_tag[20:14] = 7'd5; byp_data[191:128] = 64'h11;
    tick(); idle();
    in_valid = 4'b0001; in_src1[6:0] = 7'd5; in_src2[6:0] = 7'd7; in_payload[127:0] = 128'hB2;
    byp_valid = 4'b1011;
    byp_tag[6:0] = 7'd5;  byp_data[63:0]    = 64'h22;
    byp_tag[13:7] = 7'd7; byp_data[127:64]  = 64'h55;
    byp_tag[27:21] = 7'd5; byp_data[255:192] = 64'h33;
    push(0, 0, cyc + 2, 64'h22, 64'h55, 128'hB2);
    tick(); idle(); rf1[63:0] = 64'hAA; rf2[63:0] = 64'hBB;
    repeat (3) tick();
  endtask

  task automatic test_late_bypass();
    sel = 1; idle();
    in_valid = 4'b0001; in_src1[6:0] = 7'd5; in_src2[6:0] = 7'd6; in_payload[127:0] = 128'hC0;
    rf1[63:0] = 64'hAA; rf2[63:0] = 64'hBB;
    push(1, 0, cyc + 3, 64'h44, 64'hBB, 128'hC0);
    tick(); in_valid = '0; rf1[63:0] = 64'hFFFF; rf2[63:0] = 64'hFFFF;
    tick(); byp_valid = 4'b0001; byp_tag[6:0] = 7'd5; byp_data[63:0] = 64'h44;
    tick(); idle();
    in_valid = 4'b0100; in_src1[20:14] = 7'd12; in_src2[20:14] = 7'd13;
    in_payload[383:256] = 128'hC2;
    rf1[191:128] = 64'hAA; rf2[191:128] = 64'hCC;
    byp_valid = 4'b0001; byp_tag[6:0] = 7'd12; byp_data[63:0] = 64'h66;
    push(1, 2, cyc + 3, 64'h67, 64'hCC, 128'hC2);
    tick(); idle();
    tick(); byp_valid = 4'b0100; byp_tag[20:14] = 7'd12; byp_data[191:128] = 64'h67;
    tick(); idle();
    repeat (3) tick();
  endtask

  task automatic test_csr();
    sel = 0; idle();
    in_valid = 4'b0001; in_is_csr = 4'b0001; in_csr_addr = 12'h300;
    in_src1[6:0] = 7'd8; in_src2[6:0] = 7'd5; in_payload[127:0] = 128'hD0;
    push(0, 0, cyc + 2, 64'h31, 64'hDEAD, 128'hD0);
    #1;
    n_tests++;
    if (csr_en[0] !== 1'b1 || csr_addr[0] !== 12'h300) begin
      n_fail++; $display("FAIL csr_strobe: got en=%b addr=%h, required en=1 addr=300", csr_en[0], csr_addr[0]);
    end
    tick(); idle();
    csr_rdata = 64'hDEAD; rf1[63:0] = 64'h31; rf2[63:0] = 64'hBB;
    byp_valid = 4'b0001; byp_tag[6:0] = 7'd5; byp_data[63:0] = 64'h12;
    tick(); idle(); csr_rdata = 64'h0BAD;
    in_valid = 4'b0010; in_is_csr = 4'b0010;
    in_src1[13:7] = 7'd3; in_src2[13:7] = 7'd4; in_payload[255:128] = 128'hD1;
    push(0, 1, cyc + 2, 64'h13, 64'hC1, 128'hD1);
    #1;
    n_tests++;
    if (csr_en[0] !== 1'b0) begin
      n_fail++; $display("FAIL csr_lane1: got en=%b, required 0", csr_en[0]);
    end
    tick(); idle(); rf1[127:64] = 64'h13; rf2[127:64] = 64'hC1;
    repeat (3) tick();
  endtask

  task automatic test_recover();
    sel = 2; idle();
    in_valid = 4'b1111;
    for (int l = 0; l < NL; l++) begin
      in_src1[l*TW +: TW] = 7'(20 + l); in_src2[l*TW +: TW] = 7'(30 + l);
    end
    tick(); in_valid = '0; rf1 = '1; rf2 = '1;
    tick(); recover = 1'b1; in_valid = 4'b0001;
    tick(); idle();
    in_valid = 4'b1111;
    for (int l = 0; l < NL; l++) begin
      in_src1[l*TW +: TW] = 7'(40 + l); in_src2[l*TW +: TW] = 7'(50 + l);
      in_payload[l*PW +: PW] = 128'(32'hE0 + l);
      push(2, l, cyc + 4, 64'(32'h100 + l), 64'(32'h200 + l), 128'(32'hE0 + l));
    end
    @(negedge clk);
    n_tests++;
    if (ev[2] !== 4'b0) begin
      n_fail++; $display("FAIL recover_t3: got valid %b, required 0000", ev[2]);
    end
    tick(); idle();
    for (int l = 0; l < NL; l++) begin
      rf1[l*DW +: DW] = 64'(32'h100 + l); rf2[l*DW +: DW] = 64'(32'h200 + l);
    end
    @(negedge clk);
    n_tests++;
    if (ev[2] !== 4'b0) begin
      n_fail++; $display("FAIL recover_t4: got valid %b, required 0000", ev[2]);
    end
    repeat (5) tick();
  endtask

  task automatic test_back_to_back();
    sel = 0; idle();
    in_valid = 4'b0011; in_src1[6:0] = 7'd5; in_src1[13:7] = 7'd6;
    tick(); idle(); rf1[63:0] = 64'h5A5A; reset = 1'b1;
    tick(); reset = 1'b0;
    n_tests++;
    if (ev[0] !== 4'b0 || es1[0] !== '0 || es2[0] !== '0 || epay[0] !== '0 || csr_en[0] !== 1'b0) begin
      n_fail++; $display("FAIL reset_mid: got valid=%b src1=%h, required all zero", ev[0], es1[0]);
    end
    for (int i = 0; i < 5; i++) begin
      idle();
      if (i < 4) begin
        in_valid = 4'b0101;
        in_src1[6:0] = 7'(60 + i);   in_src2[6:0] = 7'(70 + i);
        in_src1[20:14] = 7'(80 + i); in_src2[20:14] = 7'(90 + i);
        in_payload[127:0] = 128'(32'hF0 + i); in_payload[383:256] = 128'(32'hF8 + i);
        push(0, 0, cyc + 2, 64'(32'h1000 + i), 64'(32'h2000 + i), 128'(32'hF0 + i));
        push(0, 2, cyc + 2, 64'(32'h3000 + i), 64'(32'h4000 + i), 128'(32'hF8 + i));
      end
      if (i > 0) begin
        rf1[63:0] = 64'(32'h1000 + i - 1);   rf2[63:0] = 64'(32'h2000 + i - 1);
        rf1[191:128] = 64'(32'h3000 + i - 1); rf2[191:128] = 64'(32'h4000 + i - 1);
      end
      tick();
    end
    idle();
    repeat (4) tick();
  endtask

  initial begin
    test_reset();
    test_rf_only();
    test_bypass();
    test_late_bypass();
    test_csr();
    test_recover();
    test_back_to_back();
    n_tests++;
    if (sbq.size() != 0) begin
      n_fail++; $display("FAIL sb_drain: got %0d outstanding, required 0", sbq.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
